// File: rtl/calc2_pkg.sv
// Shared types, constants and small helpers for the calc2 port driver.
package calc2_pkg;

  typedef logic [3:0] cmd_t;
  typedef logic [1:0] resp_t;
  typedef logic [1:0] tag_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_SHL = 4'd5;
  localparam cmd_t CMD_SHR = 4'd6;

  localparam resp_t RESP_NONE = 2'd0;
  localparam resp_t RESP_OK   = 2'd1;
  localparam resp_t RESP_OVF  = 2'd2;
  localparam resp_t RESP_INV  = 2'd3;

  localparam int NUM_TAGS = 4;
  localparam int AGE_W    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP1  = 2'd1,
    OP2  = 2'd2
  } iss_state_t;

  // One buffered host operation: 4 + 32 + 32 = 68 bits.
  typedef struct packed {
    cmd_t        cmd;
    logic [31:0] data1;
    logic [31:0] data2;
  } req_t;

  // Index of the lowest set bit; 0 when the vector is empty (callers gate on that).
  function automatic tag_t lowest_tag(input logic [3:0] vec);
    tag_t t;
    if (vec[0]) begin
      t = 2'd0;
    end else if (vec[1]) begin
      t = 2'd1;
    end else if (vec[2]) begin
      t = 2'd2;
    end else if (vec[3]) begin
      t = 2'd3;
    end else begin
      t = 2'd0;
    end
    return t;
  endfunction

  // Number of set bits in a 4-bit vector.
  function automatic logic [2:0] popcount4(input logic [3:0] vec);
    return {2'b00, vec[0]} + {2'b00, vec[1]} + {2'b00, vec[2]} + {2'b00, vec[3]};
  endfunction

endpackage

// File: rtl/calc2_req_fifo.sv
// Synchronous show-ahead FIFO holding host operations {cmd, data1, data2}.
module calc2_req_fifo
  import calc2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic c_clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  req_t wr_data,
  output req_t rd_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rd_data   = mem_r[rd_ptr_r];

  // Storage array: written at the write pointer on an accepted push.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/calc2_port_driver.sv
// Per-port calc2 request issuer and response tracker with tag allocation and timeouts.
module calc2_port_driver
  import calc2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic [3:0]  host_req_cmd,
  input  logic [31:0] host_req_data1,
  input  logic [31:0] host_req_data2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  output logic [1:0]  req_tag_out,
  output logic        iss_valid,
  output logic [1:0]  iss_tag,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  input  logic [1:0]  out_tag,
  output logic        host_rsp_valid,
  output logic [1:0]  host_rsp_tag,
  output logic [1:0]  host_rsp_resp,
  output logic [31:0] host_rsp_data,
  output logic        host_rsp_timeout,
  output logic [2:0]  outstanding,
  output logic        err_spurious
);

  iss_state_t       state_r;
  iss_state_t       state_nxt_s;

  req_t             fifo_wr_s;
  req_t             fifo_head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             fifo_push_s;

  logic [3:0]       in_use_r;
  logic [3:0]       in_use_nxt_s;
  logic [3:0]       release_s;
  logic [3:0]       alloc_s;
  logic [3:0]       free_s;
  logic [3:0]       pending_s;
  logic [AGE_W-1:0] age_r [NUM_TAGS];
  logic [31:0]      data2_r;

  tag_t             alloc_tag_s;
  tag_t             to_tag_s;
  logic             launch_s;
  logic             can_launch_s;
  logic             rsp_any_s;
  logic             rsp_hit_s;
  logic             spurious_s;
  logic             to_fire_s;

  logic [3:0]       req_cmd_nxt_s;
  logic [31:0]      req_data_nxt_s;
  tag_t             req_tag_nxt_s;
  logic             iss_valid_nxt_s;

  assign fifo_wr_s      = '{cmd: host_req_cmd, data1: host_req_data1, data2: host_req_data2};
  assign fifo_push_s    = host_req_valid & ~fifo_full_s;
  assign host_req_ready = ~fifo_full_s;

  calc2_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .c_clk   (c_clk),
    .reset   (reset),
    .push    (fifo_push_s),
    .pop     (launch_s),
    .wr_data (fifo_wr_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Tag bookkeeping: pending timeouts, which tag is released this cycle, and the next free tag.
  always_comb begin
    pending_s  = 4'b0000;
    release_s  = 4'b0000;
    for (int i = 0; i < NUM_TAGS; i++) begin
      pending_s[i] = in_use_r[i] && (age_r[i] == AGE_W'(TIMEOUT));
    end
    rsp_any_s  = (out_resp != RESP_NONE);
    rsp_hit_s  = rsp_any_s && in_use_r[out_tag];
    spurious_s = rsp_any_s && !in_use_r[out_tag];
    // calc2 responses always win over a pending timeout.
    to_fire_s  = !rsp_any_s && (pending_s != 4'b0000);
    to_tag_s   = lowest_tag(pending_s);
    if (rsp_hit_s) begin
      release_s[out_tag] = 1'b1;
    end else if (to_fire_s) begin
      release_s[to_tag_s] = 1'b1;
    end else begin
      release_s = 4'b0000;
    end
    // Released tags are immediately visible to the allocator.
    free_s       = ~(in_use_r & ~release_s);
    alloc_tag_s  = lowest_tag(free_s);
    can_launch_s = !fifo_empty_s && (free_s != 4'b0000);
  end

  // Issue FSM next-state and next values of the registered request outputs.
  always_comb begin
    state_nxt_s     = state_r;
    launch_s        = 1'b0;
    req_cmd_nxt_s   = CMD_NOP;
    req_data_nxt_s  = 32'd0;
    req_tag_nxt_s   = 2'd0;
    iss_valid_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (can_launch_s) begin
          state_nxt_s = OP1;
          launch_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OP1: begin
        state_nxt_s    = OP2;
        req_data_nxt_s = data2_r;
      end
      OP2: begin
        if (can_launch_s) begin
          state_nxt_s = OP1;
          launch_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (launch_s) begin
      req_cmd_nxt_s   = fifo_head_s.cmd;
      req_data_nxt_s  = fifo_head_s.data1;
      req_tag_nxt_s   = alloc_tag_s;
      iss_valid_nxt_s = 1'b1;
    end else begin
      iss_valid_nxt_s = 1'b0;
    end
    alloc_s      = launch_s ? (4'b0001 << alloc_tag_s) : 4'b0000;
    in_use_nxt_s = (in_use_r & ~release_s) | alloc_s;
  end

  // FSM state register and registered request-side outputs.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      req_cmd_out  <= CMD_NOP;
      req_data_out <= 32'd0;
      req_tag_out  <= 2'd0;
      iss_valid    <= 1'b0;
      iss_tag      <= 2'd0;
      data2_r      <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      req_cmd_out  <= req_cmd_nxt_s;
      req_data_out <= req_data_nxt_s;
      req_tag_out  <= req_tag_nxt_s;
      iss_valid    <= iss_valid_nxt_s;
      iss_tag      <= req_tag_nxt_s;
      if (launch_s) begin
        data2_r <= fifo_head_s.data2;
      end
    end
  end

  // Tag in-use vector, per-tag saturating age counters and the outstanding count.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      in_use_r    <= 4'b0000;
      outstanding <= 3'd0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        age_r[i] <= AGE_W'(0);
      end
    end else begin
      in_use_r    <= in_use_nxt_s;
      outstanding <= popcount4(in_use_nxt_s);
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (alloc_s[i] || release_s[i]) begin
          age_r[i] <= AGE_W'(0);
        end else if (in_use_r[i] && (age_r[i] != AGE_W'(TIMEOUT))) begin
          age_r[i] <= age_r[i] + AGE_W'(1);
        end
      end
    end
  end

  // Host response: calc2 result for a live tag, else the lowest pending timeout.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      host_rsp_valid   <= 1'b0;
      host_rsp_tag     <= 2'd0;
      host_rsp_resp    <= RESP_NONE;
      host_rsp_data    <= 32'd0;
      host_rsp_timeout <= 1'b0;
    end else if (rsp_hit_s) begin
      host_rsp_valid   <= 1'b1;
      host_rsp_tag     <= out_tag;
      host_rsp_resp    <= out_resp;
      host_rsp_data    <= out_data;
      host_rsp_timeout <= 1'b0;
    end else if (to_fire_s) begin
      host_rsp_valid   <= 1'b1;
      host_rsp_tag     <= to_tag_s;
      host_rsp_resp    <= RESP_NONE;
      host_rsp_data    <= 32'd0;
      host_rsp_timeout <= 1'b1;
    end else begin
      host_rsp_valid   <= 1'b0;
      host_rsp_tag     <= 2'd0;
      host_rsp_resp    <= RESP_NONE;
      host_rsp_data    <= 32'd0;
      host_rsp_timeout <= 1'b0;
    end
  end

  // Sticky flag for any calc2 response carrying a tag that is not outstanding.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      err_spurious <= 1'b0;
    end else if (spurious_s) begin
      err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc2_port_driver.sv
// Directed self-checking bench: dut_a uses the default timeout, dut_b uses TIMEOUT=8.
module tb_calc2_port_driver;

  logic        c_clk;
  logic        reset;
  logic        host_req_valid;
  logic [3:0]  host_req_cmd;
  logic [31:0] host_req_data1;
  logic [31:0] host_req_data2;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;

  logic        ready_a, ready_b;
  logic [3:0]  req_cmd_a, req_cmd_b;
  logic [31:0] req_data_a, req_data_b;
  logic [1:0]  req_tag_a, req_tag_b;
  logic        iss_valid_a, iss_valid_b;
  logic [1:0]  iss_tag_a, iss_tag_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic [1:0]  rsp_tag_a, rsp_tag_b;
  logic [1:0]  rsp_resp_a, rsp_resp_b;
  logic [31:0] rsp_data_a, rsp_data_b;
  logic        rsp_to_a, rsp_to_b;
  logic [2:0]  outst_a, outst_b;
  logic        spur_a, spur_b;

  int n_checks = 0;
  int n_fail   = 0;

  calc2_port_driver dut_a (
    .c_clk(c_clk), .reset(reset),
    .host_req_valid(host_req_valid), .host_req_ready(ready_a),
    .host_req_cmd(host_req_cmd), .host_req_data1(host_req_data1), .host_req_data2(host_req_data2),
    .req_cmd_out(req_cmd_a), .req_data_out(req_data_a), .req_tag_out(req_tag_a),
    .iss_valid(iss_valid_a), .iss_tag(iss_tag_a),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .host_rsp_valid(rsp_valid_a), .host_rsp_tag(rsp_tag_a), .host_rsp_resp(rsp_resp_a),
    .host_rsp_data(rsp_data_a), .host_rsp_timeout(rsp_to_a),
    .outstanding(outst_a), .err_spurious(spur_a)
  );

  calc2_port_driver #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut_b (
    .c_clk(c_clk), .reset(reset),
    .host_req_valid(host_req_valid), .host_req_ready(ready_b),
    .host_req_cmd(host_req_cmd), .host_req_data1(host_req_data1), .host_req_data2(host_req_data2),
    .req_cmd_out(req_cmd_b), .req_data_out(req_data_b), .req_tag_out(req_tag_b),
    .iss_valid(iss_valid_b), .iss_tag(iss_tag_b),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .host_rsp_valid(rsp_valid_b), .host_rsp_tag(rsp_tag_b), .host_rsp_resp(rsp_resp_b),
    .host_rsp_data(rsp_data_b), .host_rsp_timeout(rsp_to_b),
    .outstanding(outst_b), .err_spurious(spur_b)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [3:0] c, input logic [31:0] d1, input logic [31:0] d2);
    host_req_valid = v;
    host_req_cmd   = c;
    host_req_data1 = d1;
    host_req_data2 = d2;
  endtask

  task automatic drive_rsp(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
    out_resp = r;
    out_data = d;
    out_tag  = t;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_req(1'b0, 4'd0, 32'd0, 32'd0);
    drive_rsp(2'd0, 32'd0, 2'd0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    drive_req(1'b0, 4'd0, 32'd0, 32'd0);
    drive_rsp(2'd0, 32'd0, 2'd0);
    tick();
    tick();
    check_eq("rst_ready", 32'(ready_a), 32'd1);
    check_eq("rst_outstanding", 32'(outst_a), 32'd0);
    check_eq("rst_req_cmd", 32'(req_cmd_a), 32'd0);
    check_eq("rst_req_data", req_data_a, 32'd0);
    check_eq("rst_iss_valid", 32'(iss_valid_a), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check_eq("rst_err_spurious", 32'(spur_a), 32'd0);
    reset = 1'b1;

    // Single add 0x10 + 0x20, response at cycle 5
    drive_req(1'b1, 4'd1, 32'h10, 32'h20);
    tick();                                   // cycle 1
    drive_req(1'b0, 4'd0, 32'd0, 32'd0);
    tick();                                   // cycle 2: OP1
    check_eq("t1_iss_valid", 32'(iss_valid_a), 32'd1);
    check_eq("t1_iss_tag", 32'(iss_tag_a), 32'd0);
    check_eq("t1_op1_cmd", 32'(req_cmd_a), 32'd1);
    check_eq("t1_op1_data", req_data_a, 32'h10);
    check_eq("t1_op1_tag", 32'(req_tag_a), 32'd0);
    check_eq("t1_outstanding", 32'(outst_a), 32'd1);
    tick();                                   // cycle 3: OP2
    check_eq("t1_op2_cmd", 32'(req_cmd_a), 32'd0);
    check_eq("t1_op2_data", req_data_a, 32'h20);
    check_eq("t1_op2_iss", 32'(iss_valid_a), 32'd0);
    tick();                                   // cycle 4: IDLE
    check_eq("t1_idle_data", req_data_a, 32'd0);
    tick();                                   // cycle 5
    drive_rsp(2'd1, 32'h30, 2'd0);
    tick();                                   // cycle 6
    drive_rsp(2'd0, 32'd0, 2'd0);
    check_eq("t1_rsp_valid", 32'(rsp_valid_a), 32'd1);
    check_eq("t1_rsp_tag", 32'(rsp_tag_a), 32'd0);
    check_eq("t1_rsp_resp", 32'(rsp_resp_a), 32'd1);
    check_eq("t1_rsp_data", rsp_data_a, 32'h30);
    check_eq("t1_rsp_timeout", 32'(rsp_to_a), 32'd0);
    check_eq("t1_outstanding_end", 32'(outst_a), 32'd0);
    tick();
    check_eq("t1_rsp_pulse", 32'(rsp_valid_a), 32'd0);

    // Five back-to-back ops; tags 0..3 two cycles apart, fifth stalls
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c < 5) begin
        drive_req(1'b1, 4'd1, 32'h100 + 32'(c), 32'h200 + 32'(c));
      end else begin
        drive_req(1'b0, 4'd0, 32'd0, 32'd0);
      end
      tick();                                 // now in cycle c+1
      if ((c + 1) >= 2 && (c + 1) <= 8 && ((c + 1) % 2) == 0) begin
        check_eq("t2_iss_valid", 32'(iss_valid_a), 32'd1);
        check_eq("t2_iss_tag", 32'(iss_tag_a), 32'((c - 1) / 2));
        check_eq("t2_op1_data", req_data_a, 32'h100 + 32'((c - 1) / 2));
      end else begin
        check_eq("t2_iss_idle", 32'(iss_valid_a), 32'd0);
      end
    end
    check_eq("t2_outstanding_full", 32'(outst_a), 32'd4);
    check_eq("t2_stall_cmd", 32'(req_cmd_a), 32'd0);
    tick();                                   // cycle 13
    drive_rsp(2'd1, 32'h55, 2'd2);
    tick();                                   // cycle 14
    drive_rsp(2'd0, 32'd0, 2'd0);
    check_eq("t2_rsp_valid", 32'(rsp_valid_a), 32'd1);
    check_eq("t2_rsp_tag", 32'(rsp_tag_a), 32'd2);
    check_eq("t2_rsp_data", rsp_data_a, 32'h55);
    check_eq("t2_fifth_iss", 32'(iss_valid_a), 32'd1);
    check_eq("t2_fifth_tag", 32'(iss_tag_a), 32'd2);
    check_eq("t2_fifth_data1", req_data_a, 32'h104);
    check_eq("t2_outstanding_again", 32'(outst_a), 32'd4);
    tick();                                   // cycle 15: OP2 of fifth
    check_eq("t2_fifth_data2", req_data_a, 32'h204);

    // FIFO fills while tags are saturated; ready returns on the first pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_req(1'b1, 4'd2, 32'h300 + 32'(k), 32'h400 + 32'(k));
      tick();
    end
    drive_req(1'b0, 4'd0, 32'd0, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
    end                                       // cycle 10
    check_eq("t3_saturated", 32'(outst_a), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq("t3_ready_fill", 32'(ready_a), 32'd1);
      drive_req(1'b1, 4'd5, 32'h310 + 32'(k), 32'h410 + 32'(k));
      tick();
    end                                       // cycle 14
    check_eq("t3_ready_full", 32'(ready_a), 32'd0);
    drive_req(1'b1, 4'd6, 32'h31F, 32'h41F);
    tick();                                   // cycle 15
    check_eq("t3_ready_hold", 32'(ready_a), 32'd0);
    drive_rsp(2'd1, 32'h1, 2'd0);
    tick();                                   // cycle 16
    drive_rsp(2'd0, 32'd0, 2'd0);
    check_eq("t3_ready_resume", 32'(ready_a), 32'd1);
    check_eq("t3_pop_iss_tag", 32'(iss_tag_a), 32'd0);
    check_eq("t3_pop_data", req_data_a, 32'h310);
    tick();                                   // cycle 17: fifth op accepted
    drive_req(1'b0, 4'd0, 32'd0, 32'd0);
    check_eq("t3_ready_full_again", 32'(ready_a), 32'd0);

    // TIMEOUT=8: forced retirement at issue+9, then late response is spurious
    do_reset();
    drive_req(1'b1, 4'd1, 32'h10, 32'h20);
    tick();                                   // cycle 1
    drive_req(1'b0, 4'd0, 32'd0, 32'd0);
    tick();                                   // cycle 2: issue
    check_eq("t4_iss", 32'(iss_valid_b), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
    end                                       // cycle 10
    check_eq("t4_no_early_to", 32'(rsp_valid_b), 32'd0);
    tick();                                   // cycle 11
    check_eq("t4_to_valid", 32'(rsp_valid_b), 32'd1);
    check_eq("t4_to_flag", 32'(rsp_to_b), 32'd1);
    check_eq("t4_to_tag", 32'(rsp_tag_b), 32'd0);
    check_eq("t4_to_resp", 32'(rsp_resp_b), 32'd0);
    check_eq("t4_to_data", rsp_data_b, 32'd0);
    check_eq("t4_to_outstanding", 32'(outst_b), 32'd0);
    tick();                                   // cycle 12
    check_eq("t4_spur_before", 32'(spur_b), 32'd0);
    drive_rsp(2'd1, 32'h30, 2'd0);
    tick();                                   // cycle 13
    drive_rsp(2'd0, 32'd0, 2'd0);
    check_eq("t4_spur_set", 32'(spur_b), 32'd1);
    check_eq("t4_spur_no_rsp", 32'(rsp_valid_b), 32'd0);
    tick();
    check_eq("t4_spur_sticky", 32'(spur_b), 32'd1);

    // calc2 response beats a same-cycle pending timeout
    do_reset();
    drive_req(1'b1, 4'd1, 32'h1, 32'h2);
    tick();                                   // cycle 1
    drive_req(1'b1, 4'd2, 32'h3, 32'h4);
    tick();                                   // cycle 2: tag 0 issued
    drive_req(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    tick();                                   // cycle 4: tag 1 issued
    check_eq("t5_tag1_iss", 32'(iss_tag_b), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
    end                                       // cycle 10: tag 0 pending
    drive_rsp(2'd2, 32'hDEAD, 2'd1);
    tick();                                   // cycle 11
    drive_rsp(2'd0, 32'd0, 2'd0);
    check_eq("t5_first_tag", 32'(rsp_tag_b), 32'd1);
    check_eq("t5_first_resp", 32'(rsp_resp_b), 32'd2);
    check_eq("t5_first_data", rsp_data_b, 32'hDEAD);
    check_eq("t5_first_to", 32'(rsp_to_b), 32'd0);
    tick();                                   // cycle 12
    check_eq("t5_second_valid", 32'(rsp_valid_b), 32'd1);
    check_eq("t5_second_to", 32'(rsp_to_b), 32'd1);
    check_eq("t5_second_tag", 32'(rsp_tag_b), 32'd0);
    tick();
    check_eq("t5_outstanding", 32'(outst_b), 32'd0);

    // Reset asserted during OP1: outputs clear at once, no OP2 afterwards
    do_reset();
    drive_req(1'b1, 4'd1, 32'h77, 32'h88);
    tick();
    drive_req(1'b0, 4'd0, 32'd0, 32'd0);
    tick();                                   // cycle 2: OP1
    check_eq("t6_op1_data", req_data_a, 32'h77);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_async_data", req_data_a, 32'd0);
    check_eq("t6_async_cmd", 32'(req_cmd_a), 32'd0);
    check_eq("t6_async_iss", 32'(iss_valid_a), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("t6_no_op2", req_data_a, 32'd0);
    check_eq("t6_ready", 32'(ready_a), 32'd1);
    check_eq("t6_outstanding", 32'(outst_a), 32'd0);
    tick();
    check_eq("t6_no_reissue", 32'(iss_valid_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc2_port_driver.md
Name: calc2_port_driver

Overview:
- Per-port request issuer and response tracker, one instance per calc2 port (1-4).
- Upstream side: buffers host operations in a FIFO and serialises them onto req<n>_cmd_in / req<n>_data_in / req<n>_tag_in using the calc2 two-cycle protocol, allocating one of the four 2-bit tags per operation.
- Downstream side: consumes out_resp<n> / out_data<n> / out_tag<n>, retires the matching tag and returns the result to the host, with a per-tag timeout.

Parameters:
- FIFO_DEPTH, 4, host request FIFO entries; power of 2, minimum 2.
- TIMEOUT, 255, cycles a tag may stay outstanding before forced retirement; 1..1023.

Ports:
- c_clk  in  1  functional clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- host_req_valid  in  1  host operation offered.
- host_req_ready  out  1  FIFO not full.
- host_req_cmd  in  4  calc2 command: 1 add, 2 sub, 5 shl, 6 shr; other values are passed through unchanged.
- host_req_data1  in  32  operand 1.
- host_req_data2  in  32  operand 2.
- req_cmd_out  out  4  to calc2 req<n>_cmd_in.
- req_data_out  out  32  to calc2 req<n>_data_in.
- req_tag_out  out  2  to calc2 req<n>_tag_in.
- iss_valid  out  1  one-cycle pulse when an operation is launched.
- iss_tag  out  2  tag assigned to the launched operation.
- out_resp  in  2  from calc2: 0 none, 1 ok, 2 overflow/underflow, 3 invalid cmd.
- out_data  in  32  from calc2 result.
- out_tag  in  2  from calc2 response tag.
- host_rsp_valid  out  1  one-cycle result pulse.
- host_rsp_tag  out  2  tag being retired.
- host_rsp_resp  out  2  calc2 response code; 0 on timeout.
- host_rsp_data  out  32  result data; 0 on timeout.
- host_rsp_timeout  out  1  retirement caused by timeout.
- outstanding  out  3  count of tags in use, 0..4.
- err_spurious  out  1  sticky flag for a response with an unallocated tag.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FIFO empty; FSM in IDLE; tag-in-use vector = 0000; age counters = 0.
  - All outputs 0, except host_req_ready = 1.
- FIFO:
  - Push on host_req_valid & host_req_ready.
  - Pop on IDLE->OP1.
  - Simultaneous push/pop when full is not possible, because ready = !full.
  - Push and pop in the same cycle when non-empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Issue FSM:
  - IDLE -> OP1 when FIFO non-empty and a free tag exists.
  - In OP1 (registered outputs): req_cmd_out = cmd, req_data_out = data1, req_tag_out = allocated tag; iss_valid = 1, iss_tag = tag; the tag's in-use bit and age counter are set at this edge.
  - OP1 -> OP2 unconditionally. In OP2: req_cmd_out = 0, req_data_out = data2, req_tag_out = 0.
  - OP2 -> OP1 directly if the next op and a free tag are ready, giving back-to-back issue with 2 cycles/op. Otherwise OP2 -> IDLE, where all req outputs are 0.
- Tag allocation: lowest-numbered free tag. All four in use stalls issue; the FIFO keeps accepting until full.
- Response path: out_resp != 0 with the out_tag bit in use gives, in the next cycle, host_rsp_valid = 1 with tag/resp/data registered from calc2; the tag bit is cleared at that same edge.
- Spurious response: out_resp != 0 with the tag not in use sets err_spurious (cleared only by reset) and generates no host_rsp.
- Timeout:
  - Each in-use tag's age counter increments per cycle, saturating at TIMEOUT.
  - Reaching TIMEOUT makes the tag timeout-pending.
  - A pending timeout is retired (host_rsp_timeout = 1, resp = 0, data = 0, tag freed) only in a cycle with no calc2 response; calc2 responses have priority.
  - Among several pending tags, the lowest is retired first, one per cycle.
  - A late calc2 response to a timed-out tag counts as spurious.
- A freed tag may be re-allocated in the same cycle it is released. Release takes effect first; the allocator sees the freed bit.
- outstanding = popcount(in-use vector).
- Reset mid-operation: outstanding tags are discarded with no host_rsp. The FSM aborts, so OP2 data is never driven.

Decomposition:
- Package calc2_pkg holds:
  - typedef cmd_t [0:3]; CMD_NOP = 0, CMD_ADD = 1, CMD_SUB = 2, CMD_SHL = 5, CMD_SHR = 6.
  - typedef resp_t [0:1]; RESP_NONE = 0, RESP_OK = 1, RESP_OVF = 2, RESP_INV = 3.
  - typedef tag_t [0:1].
  - Issue FSM state enum: IDLE, OP1, OP2.
- Sub-module calc2_req_fifo: parameterised synchronous FIFO of {cmd, data1, data2}, 68 bits, with full/empty.

Test Plan:
- Single add 0x10 + 0x20; calc2 model responds resp=1, data=0x30, tag=0 at cycle 5 -> host_rsp_valid next cycle with tag 0, resp 1, data 0x30; outstanding returns to 0.
- Five back-to-back ops, no responses -> tags 0,1,2,3 issued 2 cycles apart; fifth op stalls with outstanding=4. Response on tag 2 -> fifth op issues with tag 2 within 2 cycles.
- Push FIFO_DEPTH+1 ops while tags are saturated -> host_req_ready = 0 after 4 pushes; accepting resumes on the first pop.
- TIMEOUT=8, no response -> host_rsp_timeout = 1 for tag 0 at issue+9 with resp 0, data 0. Later calc2 response on tag 0 -> err_spurious = 1.
- Calc2 response on tag 1 in the same cycle tag 0 is timeout-pending -> tag 1 result first, tag 0 timeout the following cycle.
- Reset asserted during OP1 -> req outputs 0 immediately, no OP2 cycle; outstanding = 0 and host_req_ready = 1 after release.
